// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: loader FSM state encoding,
// bytes per word and the default word-index width.
package mem_pkg;

    typedef enum logic [1:0] {
        CNT_LO = 2'd0,
        CNT_HI = 2'd1,
        DATA   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int WORD_BYTES         = 4;
    localparam int DEFAULT_ADDR_WIDTH = 8;

endpackage

// File: rtl/word_ram.sv
// Unified 32-bit word array with two combinational read ports and one
// synchronous write port. Contents are not reset.
// Ports:
//   clk       clock for the write port
//   raddr_a_i read port A word index     rdata_a_o  word at raddr_a_i
//   raddr_b_i read port B word index     rdata_b_o  word at raddr_b_i
//   we_i      write enable               waddr_i    write word index
//   wdata_i   write data
module word_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [31:0]           rdata_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [31:0]           rdata_b_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read in the write cycle sees the old contents.
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a single-cycle processor: combinational fetch
// and data reads, synchronous data write, plus a byte-serial program loader
// that fills the array after reset while holding the processor in reset.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   PC / instruction      fetch byte address / word at that address
//   WE, address_to_mem,
//   data_to_mem           processor data write (honoured only in RUN)
//   data_from_mem         word at address_to_mem
//   ld_byte, ld_valid,
//   ld_ready              loader byte stream handshake
//   cpu_reset             registered processor reset, low only in RUN
//   load_done             high in RUN
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] instruction,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    input  logic [7:0]  ld_byte,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        load_done
);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] partial_q, partial_d;
    logic        cpu_reset_q;

    logic        accept;
    logic        word_complete;
    logic        last_word;
    logic [31:0] word_asm;
    logic        ld_we;
    logic        ld_in_range;

    logic                  pc_ok, da_ok, cpu_we, ram_we;
    logic [ADDR_WIDTH-1:0] pc_idx, da_idx, ram_waddr;
    logic [31:0]           ram_wdata, rd_a, rd_b;

    assign accept        = ld_valid && ld_ready;
    // Bytes shift in from the top so byte 0 lands in [7:0] after four.
    assign word_asm      = {ld_byte, partial_q[31:8]};
    assign word_complete = accept && (state_q == DATA) &&
                           (byte_idx_q == 2'(WORD_BYTES - 1));
    assign last_word     = (word_idx_q == count_q - 16'd1);
    // Words beyond the array depth are consumed but dropped.
    assign ld_in_range   = ((32'(word_idx_q) >> ADDR_WIDTH) == 32'd0);
    assign ld_we         = word_complete && ld_in_range;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CNT_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_LO: if (accept) state_d = CNT_HI;
            CNT_HI: if (accept) state_d = ({ld_byte, count_q[7:0]} == 16'd0) ? RUN : DATA;
            DATA:   if (word_complete && last_word) state_d = RUN;
            RUN:    state_d = RUN;
            default: state_d = CNT_LO;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ld_ready  = (state_q != RUN);
        load_done = (state_q == RUN);
    end

    // Loader datapath: byte count, word pointer and word assembly.
    always_comb begin
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        partial_d  = partial_q;
        if (accept) begin
            case (state_q)
                CNT_LO: count_d[7:0] = ld_byte;
                CNT_HI: begin
                    count_d[15:8] = ld_byte;
                    word_idx_d    = 16'd0;
                    byte_idx_d    = 2'd0;
                end
                DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    partial_d  = word_asm;
                    if (word_complete) word_idx_d = word_idx_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            partial_q   <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            partial_q   <= partial_d;
            cpu_reset_q <= (state_d != RUN);
        end
    end

    assign cpu_reset = cpu_reset_q;

    // Address decode: word index from [ADDR_WIDTH+1:2], upper bits must be zero.
    assign pc_ok  = ((PC >> (ADDR_WIDTH + 2)) == 32'd0);
    assign da_ok  = ((address_to_mem >> (ADDR_WIDTH + 2)) == 32'd0);
    assign pc_idx = PC[ADDR_WIDTH+1:2];
    assign da_idx = address_to_mem[ADDR_WIDTH+1:2];

    // The loader never writes in RUN, so the two write sources never collide.
    assign cpu_we    = WE && (state_q == RUN) && da_ok;
    assign ram_we    = ld_we || cpu_we;
    assign ram_waddr = ld_we ? word_idx_q[ADDR_WIDTH-1:0] : da_idx;
    assign ram_wdata = ld_we ? word_asm : data_to_mem;

    word_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .raddr_a_i (pc_idx),
        .rdata_a_o (rd_a),
        .raddr_b_i (da_idx),
        .rdata_b_o (rd_b),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata)
    );

    assign instruction   = pc_ok ? rd_a : 32'h0;
    assign data_from_mem = da_ok ? rd_b : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        cpu_reset;
    logic        load_done;

    int n_run;
    int n_fail;

    mem_responder #(.ADDR_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .PC             (PC),
        .instruction    (instruction),
        .WE             (WE),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem),
        .ld_byte        (ld_byte),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .cpu_reset      (cpu_reset),
        .load_done      (load_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] basic_stream [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                                      8'h93, 8'h05, 8'h60, 8'h00};

    // Present one byte for exactly one rising edge, then sample 1 ns later.
    task automatic send_byte(input logic [7:0] b);
        ld_byte  = b;
        ld_valid = 1'b1;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_run++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
        n_run++;
        if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
        n_run++;
        if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        idle_cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_basic_load();
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(basic_stream[i]);
        n_run++;
        if (load_done !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL basic_before_last done=%b cpu_reset=%b exp 0/1", load_done, cpu_reset);
        end
        send_byte(basic_stream[9]);
        n_run++;
        if (load_done !== 1'b1 || cpu_reset !== 1'b0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_enter_run done=%b cpu_reset=%b ready=%b exp 1/0/0", load_done, cpu_reset, ld_ready);
        end
        PC = 32'h0; #1;
        n_run++;
        if (instruction !== 32'h00500513) begin n_fail++; $display("FAIL basic_word0 got=%h exp=00500513", instruction); end
        PC = 32'h4; #1;
        n_run++;
        if (instruction !== 32'h00600593) begin n_fail++; $display("FAIL basic_word1 got=%h exp=00600593", instruction); end
        PC = 32'h7; #1;
        n_run++;
        if (instruction !== 32'h00600593) begin n_fail++; $display("FAIL basic_pc_low_bits got=%h exp=00600593", instruction); end
        PC = 32'h400; #1;
        n_run++;
        if (instruction !== 32'h0) begin n_fail++; $display("FAIL basic_pc_out_of_range got=%h exp=0", instruction); end
        PC = 32'h0;
    endtask

    task automatic test_stalled();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ld_byte  = 8'hA5;
            ld_valid = 1'b0;
            idle_cycle();
            n_run++;
            if (ld_ready !== 1'b1 || load_done !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold idx=%0d ready=%b done=%b exp 1/0", i, ld_ready, load_done);
            end
            send_byte(basic_stream[i]);
        end
        n_run++;
        if (load_done !== 1'b1) begin n_fail++; $display("FAIL stall_done got=%b exp=1", load_done); end
        PC = 32'h0; #1;
        n_run++;
        if (instruction !== 32'h00500513) begin n_fail++; $display("FAIL stall_word0 got=%h exp=00500513", instruction); end
        PC = 32'h4; #1;
        n_run++;
        if (instruction !== 32'h00600593) begin n_fail++; $display("FAIL stall_word1 got=%h exp=00600593", instruction); end
        PC = 32'h0;
    endtask

    task automatic test_zero_count();
        do_reset();
        send_byte(8'h00);
        n_run++;
        if (load_done !== 1'b0 || ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_after_lo done=%b ready=%b exp 0/1", load_done, ld_ready);
        end
        send_byte(8'h00);
        n_run++;
        if (load_done !== 1'b1 || ld_ready !== 1'b0 || cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_enter_run done=%b ready=%b cpu_reset=%b exp 1/0/0", load_done, ld_ready, cpu_reset);
        end
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        n_run++;
        if (load_done !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL zero_ignore done=%b ready=%b exp 1/0", load_done, ld_ready);
        end
        // Contents from the previous load survive a zero-length load.
        PC = 32'h0; #1;
        n_run++;
        if (instruction !== 32'h00500513) begin n_fail++; $display("FAIL zero_keep_mem got=%h exp=00500513", instruction); end
    endtask

    task automatic test_data_port();
        WE = 1'b1; address_to_mem = 32'h10; data_to_mem = 32'h11111111;
        idle_cycle();
        data_to_mem = 32'hDEADBEEF; #1;
        n_run++;
        if (data_from_mem !== 32'h11111111) begin
            n_fail++; $display("FAIL data_old_value got=%h exp=11111111", data_from_mem);
        end
        idle_cycle();
        WE = 1'b0;
        n_run++;
        if (data_from_mem !== 32'hDEADBEEF) begin n_fail++; $display("FAIL data_write got=%h exp=deadbeef", data_from_mem); end
        address_to_mem = 32'h13; #1;
        n_run++;
        if (data_from_mem !== 32'hDEADBEEF) begin n_fail++; $display("FAIL data_low_bits got=%h exp=deadbeef", data_from_mem); end
        WE = 1'b1; address_to_mem = 32'h400; data_to_mem = 32'hCAFEF00D;
        idle_cycle();
        WE = 1'b0; #1;
        n_run++;
        if (data_from_mem !== 32'h0) begin n_fail++; $display("FAIL data_oor_read got=%h exp=0", data_from_mem); end
        address_to_mem = 32'h0; #1;
        n_run++;
        if (data_from_mem !== 32'h00500513) begin n_fail++; $display("FAIL data_oor_alias got=%h exp=00500513", data_from_mem); end
    endtask

    task automatic test_write_blocked();
        do_reset();
        WE = 1'b1; address_to_mem = 32'h0; data_to_mem = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) send_byte(basic_stream[i]);
        WE = 1'b0;
        PC = 32'h0; #1;
        n_run++;
        if (instruction !== 32'h00500513) begin n_fail++; $display("FAIL blocked_word0 got=%h exp=00500513", instruction); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(basic_stream[i]);
        reset = 1'b1; #1;
        n_run++;
        if (cpu_reset !== 1'b1 || ld_ready !== 1'b1 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abort cpu_reset=%b ready=%b done=%b exp 1/1/0", cpu_reset, ld_ready, load_done);
        end
        idle_cycle();
        reset = 1'b0; #1;
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h89);
        n_run++;
        if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
            n_fail++; $display("FAIL midreset_done done=%b cpu_reset=%b exp 1/0", load_done, cpu_reset);
        end
        PC = 32'h0; #1;
        n_run++;
        if (instruction !== 32'h12345678) begin n_fail++; $display("FAIL midreset_word0 got=%h exp=12345678", instruction); end
        PC = 32'h4; #1;
        n_run++;
        if (instruction !== 32'h89ABCDEF) begin n_fail++; $display("FAIL midreset_word1 got=%h exp=89abcdef", instruction); end
    endtask

    // 257 words into a 256-word array: the extra word must not alias to word 0.
    task automatic test_overflow();
        logic [31:0] w;
        do_reset();
        send_byte(8'h01); send_byte(8'h01);
        for (int k = 0; k < 257; k++) begin
            w = (k == 0) ? 32'hA0000000 : (k == 256) ? 32'hBBBBBBBB : 32'(k);
            for (int b = 0; b < 4; b++) begin
                if (k == 256 && b == 3) begin
                    n_run++;
                    if (load_done !== 1'b0) begin n_fail++; $display("FAIL ovf_early_done got=%b exp=0", load_done); end
                end
                send_byte(w[8*b +: 8]);
            end
        end
        n_run++;
        if (load_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done got=%b exp=1", load_done); end
        PC = 32'h0; #1;
        n_run++;
        if (instruction !== 32'hA0000000) begin n_fail++; $display("FAIL ovf_word0 got=%h exp=a0000000", instruction); end
        PC = 32'h3FC; #1;
        n_run++;
        if (instruction !== 32'h000000FF) begin n_fail++; $display("FAIL ovf_word255 got=%h exp=000000ff", instruction); end
        PC = 32'h0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        reset = 1'b1;
        PC = 32'h0;
        WE = 1'b0;
        address_to_mem = 32'h0;
        data_to_mem = 32'h0;
        ld_byte = 8'h0;
        ld_valid = 1'b0;
        #1;
        test_reset();
        test_basic_load();
        test_stalled();
        test_zero_count();
        test_data_port();
        test_write_blocked();
        test_reset_mid_load();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-cycle processor's fetch and data ports: one unified word array serving a combinational instruction read, a combinational data read and a synchronous data write. Also contains a byte-serial program loader that fills the array after reset while holding the processor in reset, then releases it. Sits between the testbench or host byte source and the processor core.

## Interface
- ADDR_WIDTH, 8, word-index width; array depth is 2**ADDR_WIDTH 32-bit words (default 256 words, byte addresses 0x000–0x3FF).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC  input  32  fetch byte address from the processor.
- instruction  output  32  word at PC.
- WE  input  1  processor data write enable.
- address_to_mem  input  32  data byte address.
- data_to_mem  input  32  write data.
- data_from_mem  output  32  word at address_to_mem.
- ld_byte  input  8  loader byte.
- ld_valid  input  1  ld_byte is valid.
- ld_ready  output  1  loader accepts a byte this cycle.
- cpu_reset  output  1  registered; drives the processor's reset input.
- load_done  output  1  high in RUN.

## Operation
- Address decode for PC and address_to_mem: word index = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored. In range iff addr[31:ADDR_WIDTH+2] == 0.
- Reads are combinational. An out-of-range address returns 32'h0.
- Processor write: mem[idx] <= data_to_mem at the edge where WE=1, state is RUN and the address is in range. It is ignored otherwise, including for the whole load phase.
- Loader FSM states:
  - CNT_LO: on accept, count[7:0] <= ld_byte; go to CNT_HI.
  - CNT_HI: on accept, count[15:8] <= ld_byte. If the resulting count is 0, go to RUN; otherwise go to DATA with word_idx=0, byte_idx=0.
  - DATA: bytes arrive little-endian (byte 0 goes to bits [7:0]). On accept, byte_idx increments mod 4. On the accept with byte_idx=3, the assembled word is written to mem[word_idx], then word_idx increments. If word_idx == count-1 at that edge, go to RUN.
  - RUN: terminal state. Left only by reset.
- Accept = ld_valid && ld_ready at a rising edge. ld_ready = 1 in CNT_LO, CNT_HI and DATA; 0 in RUN. ld_ready does not depend on ld_valid.
- If count > 2**ADDR_WIDTH, words with word_idx ≥ depth are consumed but not written.
- cpu_reset = 1 in all states except RUN. load_done = (state == RUN).
- Reset values: state CNT_LO, count 0, word_idx 0, byte_idx 0, partial word 0, cpu_reset 1, load_done 0, ld_ready 1. Array contents are not reset.
- Reset asserted mid-load aborts the load immediately. Words already written stay in the array. The next load starts again from CNT_LO.

## Timing
- Read latency 0: instruction and data_from_mem follow their address inputs in the same cycle.
- A write is visible to reads from the cycle after its edge. A read of the same address in the write cycle returns the old value.
- A loader word write occurs at the edge of its 4th byte accept. The word is readable in the next cycle.
- cpu_reset and load_done change at the edge that enters RUN:
  - normally the final byte's accept edge;
  - for count=0, the CNT_HI accept edge.
- The processor's first fetch (PC=0) therefore happens in the cycle after that edge.
- Minimum load time: 2 + 4·count accepted bytes. ld_valid gaps stall the FSM with no state change.

## Structure
- Shared package `mem_pkg`:
  - state enum {CNT_LO, CNT_HI, DATA, RUN};
  - constant WORD_BYTES=4;
  - localparam for the default ADDR_WIDTH.
- One sub-module `word_ram`: 2 combinational read ports and 1 synchronous write port, parameterised by ADDR_WIDTH, no reset.
- Loader FSM and address decode stay in mem_responder.

## Test plan
- Basic load:
  - stimulus: bytes 02,00, 13,05,50,00, 93,05,60,00, ld_valid always 1;
  - response: mem[0]=32'h00500513, mem[1]=32'h00600593; load_done rises after byte 10; instruction=32'h00500513 with PC=0 in the next cycle.
- Stalled handshake:
  - stimulus: same stream with ld_valid toggling every cycle;
  - response: identical contents; state holds during ld_valid=0.
- Zero count:
  - stimulus: bytes 00,00;
  - response: RUN entered at the 2nd accept; ld_ready=0 afterwards; further bytes ignored.
- Data port after load:
  - stimulus: WE=1, address_to_mem=0x10, data_to_mem=32'hDEADBEEF;
  - response: data_from_mem=0xDEADBEEF from the next cycle. A write to 0x400 is dropped, and a read of 0x400 returns 0. address 0x13 reads word 4.
- Writes blocked during load:
  - stimulus: WE=1, address 0x0 during DATA;
  - response: mem[0] holds only the loaded value.
- Reset mid-load:
  - stimulus: reset asserted after 5 bytes of a 2-word load;
  - response: cpu_reset=1 and ld_ready=1 immediately; a fresh load completes correctly.
